// File: rtl/seq_datapath_ctrl_pkg.sv
// Shared definitions for the self-sequencing three-register datapath:
// FSM state encoding and arithmetic operation selectors.
package seq_datapath_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/BinTo7Seg.sv
// Hex nibble to 7-segment decoder (active-high segments, bit order gfedcba).
// Ports: bin - 4-bit value; seg - segment pattern.
module BinTo7Seg (
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bin)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seq_step_unit.sv
// One sequence step: r1 op r2 with carry/borrow, plus the r3 accumulation
// with its carry-out. Purely combinational.
// Ports: r1/r2/r3 - current registers; f - op select;
//        step_c - new r2; acc_c - new r3; c1_c - op carry/borrow; c2_c - acc carry.
module seq_step_unit
  import seq_datapath_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  input  logic             f,
  output logic [WIDTH-1:0] step_c,
  output logic [WIDTH-1:0] acc_c,
  output logic             c1_c,
  output logic             c2_c
);

  logic [WIDTH:0] s_wide;
  logic [WIDTH:0] acc_wide;

  // Bit WIDTH of the widened result is the carry for add and the borrow
  // (r1 < r2 unsigned) for subtract.
  always_comb begin
    if (f == OP_SUB) begin
      s_wide = {1'b0, r1} - {1'b0, r2};
    end else begin
      s_wide = {1'b0, r1} + {1'b0, r2};
    end
    acc_wide = {1'b0, r3} + {1'b0, s_wide[WIDTH-1:0]};
  end

  assign step_c = s_wide[WIDTH-1:0];
  assign c1_c   = s_wide[WIDTH];
  assign acc_c  = acc_wide[WIDTH-1:0];
  assign c2_c   = acc_wide[WIDTH];

endmodule

// File: rtl/seq_datapath_ctrl.sv
// Self-sequencing three-register datapath: loads two operands on start,
// then runs n_steps steps (r1<=r2, r2<=r1 op r2, r3+=result) and pulses done.
// Ports: cl/rst - clock, async active-high reset; start, a_in, b_in, f,
//        n_steps - run request and its operands; busy/done/ovf - status;
//        r1..r3 - register contents; x1..x3 - 7-seg codes, 7 bits per nibble.
module seq_datapath_ctrl
  import seq_datapath_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   cl,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [WIDTH-1:0]       b_in,
  input  logic                   f,
  input  logic [CNT_W-1:0]       n_steps,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  output logic [WIDTH-1:0]       r1,
  output logic [WIDTH-1:0]       r2,
  output logic [WIDTH-1:0]       r3,
  output logic [7*WIDTH/4-1:0]   x1,
  output logic [7*WIDTH/4-1:0]   x2,
  output logic [7*WIDTH/4-1:0]   x3
);

  localparam int unsigned NDIG = WIDTH / 4;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] r3_q, r3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             f_q, f_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] acc_c;
  logic             c1_c;
  logic             c2_c;

  seq_step_unit #(.WIDTH(WIDTH)) u_step (
    .r1     (r1_q),
    .r2     (r2_q),
    .r3     (r3_q),
    .f      (f_q),
    .step_c (step_c),
    .acc_c  (acc_c),
    .c1_c   (c1_c),
    .c2_c   (c2_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          r1_d    = a_in;
          r2_d    = b_in;
          r3_d    = '0;
          ovf_d   = 1'b0;
          f_d     = f;
          cnt_d   = n_steps;
          // A zero-step request loads operands and completes immediately.
          state_d = (n_steps != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        r1_d  = r2_q;
        r2_d  = step_c;
        r3_d  = acc_c;
        ovf_d = ovf_q | c1_c | c2_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge cl or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      cnt_q   <= '0;
      f_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign ovf  = ovf_q;
  assign r1   = r1_q;
  assign r2   = r2_q;
  assign r3   = r3_q;

  // One decoder per nibble per register.
  for (genvar k = 0; k < NDIG; k++) begin : g_disp
    BinTo7Seg u_x1 (.bin(r1_q[4*k +: 4]), .seg(x1[7*k +: 7]));
    BinTo7Seg u_x2 (.bin(r2_q[4*k +: 4]), .seg(x2[7*k +: 7]));
    BinTo7Seg u_x3 (.bin(r3_q[4*k +: 4]), .seg(x3[7*k +: 7]));
  end

endmodule
